// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register slave: frame geometry, address map,
// STATUS bit positions and the frame FSM state encoding.
package spi_reg_pkg;

    localparam int CMD_BITS  = 8;
    localparam int DATA_BITS = 32;
    localparam int CNT_W     = 6;

    localparam logic [6:0] ADDR_VERSION   = 7'h00;
    localparam logic [6:0] ADDR_DEBUG     = 7'h01;
    localparam logic [6:0] ADDR_STATUS    = 7'h02;
    localparam logic [6:0] ADDR_EN_CORDIC = 7'h03;
    localparam logic [6:0] ADDR_FREQ_BASE = 7'h10;
    localparam logic [6:0] ADDR_FREQ_1    = 7'h10;
    localparam logic [6:0] ADDR_FREQ_2    = 7'h11;
    localparam logic [6:0] ADDR_FREQ_3    = 7'h12;
    localparam logic [6:0] ADDR_FREQ_4    = 7'h13;
    localparam logic [6:0] ADDR_FREQ_5    = 7'h14;
    localparam logic [6:0] ADDR_FREQ_6    = 7'h15;
    localparam logic [6:0] ADDR_FREQ_7    = 7'h16;
    localparam logic [6:0] ADDR_FREQ_8    = 7'h17;
    localparam logic [6:0] ADDR_FREQ_9    = 7'h18;
    localparam logic [6:0] ADDR_FREQ_10   = 7'h19;
    localparam logic [6:0] ADDR_FREQ_11   = 7'h1A;

    localparam int STATUS_EN_CORDIC  = 0;
    localparam int STATUS_CORDIC_DONE = 1;
    localparam int STATUS_BINS_VALID = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus a third flop so
// rising and falling edges of the synchronized level can be detected.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchronizer chain followed by the edge-detect delay flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            dly_q  <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~dly_q;
    assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder and configuration register file for the Goertzel /
// CORDIC core. Frames are 8 command bits (rw + address) then 32 data bits.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no frame; MISO held 0, waiting for ss_n to fall
//   CMD     | shifting in the 8-bit command; MISO 0
//   DATA    | shifting 32 bits in; read data shifted out on SCK falls
//   DONE    | frame complete, SCK ignored, waiting for ss_n to rise
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int          NF          = 11,
    parameter logic [31:0] VERSION_RST = 32'h3202_4003
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             spi_sck,
    input  logic             spi_ss_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    input  logic             cordic_done_i,
    input  logic             bins_valid_i,
    output logic [NF*32-1:0] freq_o,
    output logic             en_cordic_o,
    output logic             cordic_start_o
);

    logic sck_rise, sck_fall, sck_s;
    logic ss_rise, ss_fall, ss_s;
    logic mosi_s;
    logic [1:0] mosi_edge_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rstn(rstn), .d_i(spi_sck),
        .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rstn(rstn), .d_i(spi_ss_n),
        .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rstn(rstn), .d_i(spi_mosi),
        .q_o(mosi_s), .rise_o(mosi_edge_unused[1]), .fall_o(mosi_edge_unused[0])
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [31:0]       shift_in_q, shift_in_d;
    logic [31:0]       shift_out_q, shift_out_d;
    logic              miso_q, miso_d;
    logic              commit_q, commit_d;

    logic [31:0]       version_q, version_d;
    logic [31:0]       debug_q, debug_d;
    logic              en_cordic_q, en_cordic_d;
    logic              cordic_start_q, cordic_start_d;
    logic [31:0]       freq_q [NF];
    logic [31:0]       freq_d [NF];

    logic [6:0]        rd_addr;
    logic [31:0]       rd_data;

    // The address is only complete on the 8th rise, so the last bit comes
    // straight from the synchronized MOSI rather than from cmd_q.
    assign rd_addr = {cmd_q[5:0], mosi_s};

    // Read mux: the value snapshotted into the shift-out register.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_VERSION:   rd_data = version_q;
            ADDR_DEBUG:     rd_data = debug_q;
            ADDR_STATUS: begin
                rd_data[STATUS_EN_CORDIC]   = en_cordic_q;
                rd_data[STATUS_CORDIC_DONE] = cordic_done_i;
                rd_data[STATUS_BINS_VALID]  = bins_valid_i;
            end
            ADDR_EN_CORDIC: rd_data[0] = en_cordic_q;
            default: ;
        endcase
        for (int i = 0; i < NF; i++) begin
            if (rd_addr == ADDR_FREQ_BASE + 7'(i)) rd_data = freq_q[i];
        end
    end

    // Frame FSM next-state: command/data shifting, MISO on SCK falls, aborts.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        miso_d      = miso_q;
        commit_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                end
            end
            ST_CMD: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    cmd_d = {cmd_q[6:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        bit_cnt_d   = '0;
                        state_d     = ST_DATA;
                        // Writes shift out zeros so MISO stays low.
                        shift_out_d = cmd_d[7] ? 32'h0 : rd_data;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else begin
                    if (sck_fall) begin
                        miso_d      = shift_out_q[31];
                        shift_out_d = {shift_out_q[30:0], 1'b0};
                    end
                    if (sck_rise) begin
                        shift_in_d = {shift_in_q[30:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_d  = ST_DONE;
                            miso_d   = 1'b0;
                            commit_d = cmd_q[7];
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
                if (ss_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file update, one cycle after the frame completes.
    always_comb begin
        version_d      = version_q;
        debug_d        = debug_q;
        en_cordic_d    = en_cordic_q;
        cordic_start_d = 1'b0;
        freq_d         = freq_q;
        if (commit_q) begin
            case (cmd_q[6:0])
                ADDR_VERSION:   version_d = shift_in_q;
                ADDR_DEBUG:     debug_d   = shift_in_q;
                ADDR_EN_CORDIC: begin
                    en_cordic_d    = shift_in_q[0];
                    cordic_start_d = shift_in_q[0];
                end
                default: ;
            endcase
            for (int i = 0; i < NF; i++) begin
                if (cmd_q[6:0] == ADDR_FREQ_BASE + 7'(i)) freq_d[i] = shift_in_q;
            end
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            cmd_q          <= '0;
            shift_in_q     <= '0;
            shift_out_q    <= '0;
            miso_q         <= 1'b0;
            commit_q       <= 1'b0;
            version_q      <= VERSION_RST;
            debug_q        <= '0;
            en_cordic_q    <= 1'b0;
            cordic_start_q <= 1'b0;
            freq_q         <= '{default: '0};
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            cmd_q          <= cmd_d;
            shift_in_q     <= shift_in_d;
            shift_out_q    <= shift_out_d;
            miso_q         <= miso_d;
            commit_q       <= commit_d;
            version_q      <= version_d;
            debug_q        <= debug_d;
            en_cordic_q    <= en_cordic_d;
            cordic_start_q <= cordic_start_d;
            freq_q         <= freq_d;
        end
    end

    // Flatten the frequency registers onto the output bus, FREQ_1 lowest.
    always_comb begin
        freq_o = '0;
        for (int i = 0; i < NF; i++) freq_o[i*32 +: 32] = freq_q[i];
    end

    assign spi_miso       = miso_q;
    assign en_cordic_o    = en_cordic_q;
    assign cordic_start_o = cordic_start_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: a bit-banged SPI host drives frames, read results
// go through an expected-value queue checked by a separate monitor.
`timescale 1ns/1ps
module tb_spi_reg_slave;

    localparam int NF = 11;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             spi_sck = 1'b0;
    logic             spi_ss_n = 1'b1;
    logic             spi_mosi = 1'b0;
    logic             spi_miso;
    logic             cordic_done_i = 1'b0;
    logic             bins_valid_i = 1'b0;
    logic [NF*32-1:0] freq_o;
    logic             en_cordic_o;
    logic             cordic_start_o;

    always #5 clk = ~clk;

    spi_reg_slave #(.NF(NF), .VERSION_RST(32'h3202_4003)) dut (
        .clk(clk),
        .rstn(rstn),
        .spi_sck(spi_sck),
        .spi_ss_n(spi_ss_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .cordic_done_i(cordic_done_i),
        .bins_valid_i(bins_valid_i),
        .freq_o(freq_o),
        .en_cordic_o(en_cordic_o),
        .cordic_start_o(cordic_start_o)
    );

    int pass_cnt = 0;
    int tot_cnt = 0;
    int start_cnt = 0;

    logic [38:0]      exp_q [$];
    logic [38:0]      exp_e;
    logic             rx_valid = 1'b0;
    logic [31:0]      rx_word = '0;
    logic [NF*32-1:0] lat_freq = '0;
    logic             lat_en = 1'b0;

    logic [31:0] freq_tbl [NF] = '{32'd1000, 32'd1500, 32'd2000, 32'd3000, 32'd4000,
                                   32'd5000, 32'd6000, 32'd7000, 32'd8000, 32'd9000,
                                   32'd10000};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (rstn && cordic_start_o) start_cnt++;
    end

    // Monitor: every completed read frame pops one expectation.
    always @(negedge clk) begin
        if (rx_valid) begin
            tot_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL read_unexpected: got %h expected none", rx_word);
            end else begin
                exp_e = exp_q.pop_front();
                if (rx_word === exp_e[31:0]) pass_cnt++;
                else $display("FAIL read addr %h: got %h expected %h", exp_e[38:32], rx_word, exp_e[31:0]);
            end
        end
    end

    // SCK half period is 4 clk cycles. After the 40th rise, outputs are
    // captured exactly 4 clk later to bound write latency.
    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] data,
                             input int nbits, input bit rst_abort);
        logic [39:0] fr;
        logic [31:0] rx;
        fr = {cmd, data};
        rx = '0;
        @(negedge clk);
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = fr[39-i];
            repeat (4) @(negedge clk);
            if (i >= 8) rx[39-i] = spi_miso;
            spi_sck = 1'b1;
            if (i == 39) begin
                repeat (4) @(posedge clk);
                #1;
                lat_freq = freq_o;
                lat_en   = en_cordic_o;
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (rst_abort) begin
            rstn = 1'b0;
            repeat (3) @(negedge clk);
            spi_ss_n = 1'b1;
            rstn = 1'b1;
        end else begin
            spi_ss_n = 1'b1;
        end
        spi_mosi = 1'b0;
        if (nbits == 40 && !cmd[7]) begin
            @(posedge clk);
            rx_word  = rx;
            rx_valid = 1'b1;
            @(posedge clk);
            rx_valid = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [31:0] data);
        spi_frame({1'b1, addr}, data, 40, 1'b0);
    endtask

    task automatic rd(input logic [6:0] addr, input logic [31:0] exp);
        exp_q.push_back({addr, exp});
        spi_frame({1'b0, addr}, 32'hA5A5_5A5A, 40, 1'b0);
    endtask

    logic miso_seen;
    int   s0;

    initial begin
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        for (int i = 0; i < NF; i++) check($sformatf("freq_rst_%0d", i), freq_o[i*32 +: 32], 32'h0);
        check("en_cordic_rst", {31'h0, en_cordic_o}, 32'h0);
        check("cordic_start_rst", {31'h0, cordic_start_o}, 32'h0);
        miso_seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            miso_seen = miso_seen | spi_miso;
        end
        check("miso_idle", {31'h0, miso_seen}, 32'h0);
        rd(7'h00, 32'h3202_4003);
        rd(7'h01, 32'h0000_0000);

        // Read/write
        wr(7'h00, 32'h3202_4003);
        wr(7'h01, 32'h0F0F_0F0F);
        rd(7'h00, 32'h3202_4003);
        rd(7'h01, 32'h0F0F_0F0F);

        // Frequency bins, each checked 4 clk after its final SCK rise
        for (int i = 0; i < NF; i++) begin
            wr(7'h10 + 7'(i), freq_tbl[i]);
            check($sformatf("freq_lat_%0d", i), lat_freq[i*32 +: 32], freq_tbl[i]);
        end
        for (int i = 0; i < NF; i++) rd(7'h10 + 7'(i), freq_tbl[i]);

        // CORDIC enable and status
        s0 = start_cnt;
        wr(7'h03, 32'h0000_0001);
        check("en_cordic_lat", {31'h0, lat_en}, 32'h1);
        check("start_pulse_1", 32'(start_cnt - s0), 32'd1);
        rd(7'h03, 32'h0000_0001);
        rd(7'h02, 32'h0000_0001);
        cordic_done_i = 1'b1;
        rd(7'h02, 32'h0000_0003);
        bins_valid_i = 1'b1;
        rd(7'h02, 32'h0000_0007);
        s0 = start_cnt;
        wr(7'h03, 32'h0000_0001);
        check("start_pulse_again", 32'(start_cnt - s0), 32'd1);

        // Abort and ignored writes
        spi_frame(8'h81, 32'hDEAD_BEEF, 20, 1'b0);
        rd(7'h01, 32'h0F0F_0F0F);
        s0 = start_cnt;
        wr(7'h02, 32'hFFFF_FFFF);
        rd(7'h02, 32'h0000_0007);
        wr(7'h7F, 32'h0000_0001);
        rd(7'h7F, 32'h0000_0000);
        check("en_after_ignored", {31'h0, en_cordic_o}, 32'h1);
        check("start_after_ignored", 32'(start_cnt - s0), 32'd0);
        wr(7'h03, 32'h0000_0000);
        check("start_on_disable", 32'(start_cnt - s0), 32'd0);
        check("en_cleared", {31'h0, en_cordic_o}, 32'h0);
        rd(7'h02, 32'h0000_0006);

        // Reset during the data phase of a FREQ_3 write
        spi_frame(8'h92, 32'h1234_5678, 20, 1'b1);
        check("freq3_after_rst", freq_o[2*32 +: 32], 32'h0);
        check("freq1_after_rst", freq_o[0 +: 32], 32'h0);
        rd(7'h01, 32'h0000_0000);
        wr(7'h12, 32'h0000_07D0);
        check("freq3_after_restart", lat_freq[2*32 +: 32], 32'h0000_07D0);
        rd(7'h12, 32'h0000_07D0);

        repeat (4) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
